// File: rtl/hgame_btn_front.sv
// Purpose : debounced three-button front end; gathers presses into one round vector per round.
// Latency : first press at BTN input -> round vector after (2 if HGAME_BTN_SYNC_EN) + DB_CYCLES + WIN_CYCLES + 1 cycles.
// Backpress: none; the game core must take the one-cycle A/B/C pulse. Presses arriving during HOLD are dropped.
//
// Optional feature macro: HGAME_BTN_SYNC_EN
//   defined   -> each BTN input passes a two-flop synchronizer (+2 cycles latency)
//   undefined -> the debouncers sample BTN inputs directly
//
// Ports:
//   CLK                  single clock, rising edge
//   RST                  asynchronous, active-low reset
//   BTN_A, BTN_B, BTN_C  raw bouncing buttons, 1 = pressed
//   A, B, C              registered round vector, nonzero for exactly one cycle per round
//   BUSY                 registered, 1 while a round is collected, emitted or awaiting release
//   ROUNDS               registered count of emitted round vectors (wraps 255 -> 0)
module hgame_btn_front #(
  parameter int DB_CYCLES  = 4,  // 1..255
  parameter int WIN_CYCLES = 3   // 1..15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_A,
  input  logic       BTN_B,
  input  logic       BTN_C,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic [7:0] ROUNDS
);

  // Last count value before the debounced level flips; the counter never
  // exceeds DB_CYCLES-1, so eight bits are always enough.
  localparam logic [7:0] DB_LAST  = 8'(DB_CYCLES - 1);
  localparam logic [3:0] WIN_LOAD = 4'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Bit order everywhere is {A, B, C}: bit 2 = A, bit 0 = C.
  logic [2:0] raw;
  logic [2:0] lvl;       // level seen by the debouncers
  logic [2:0] db;        // debounced levels
  logic [2:0] db_q;      // debounced levels one cycle ago
  logic [2:0] press;     // one-cycle press events

  assign raw = {BTN_A, BTN_B, BTN_C};

  // ---------------------------------------------------------------------------
  // Input synchronizer (optional)
  // ---------------------------------------------------------------------------
`ifdef HGAME_BTN_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2;
`else
  assign lvl = raw;
`endif

  // ---------------------------------------------------------------------------
  // Per-button debouncers
  // The counter runs only while the sampled level disagrees with the
  // debounced level; any agreement restarts it, so a bounce shorter than
  // DB_CYCLES never reaches the debounced output.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [7:0] cnt;
    logic       lvl_db;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        cnt    <= 8'd0;
        lvl_db <= 1'b0;
      end else if (lvl[i] == lvl_db) begin
        cnt    <= 8'd0;
      end else if (cnt == DB_LAST) begin
        cnt    <= 8'd0;
        lvl_db <= ~lvl_db;
      end else begin
        cnt    <= cnt + 8'd1;
      end
    end

    assign db[i] = lvl_db;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      db_q <= 3'b000;
    end else begin
      db_q <= db;
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press = db & ~db_q;

  // ---------------------------------------------------------------------------
  // Round FSM
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [2:0] mask;
  logic [2:0] mask_nxt;
  logic [3:0] win;
  logic [3:0] win_nxt;
  logic [2:0] abc_q;

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    win_nxt   = win;

    unique case (state)
      S_IDLE: begin
        if (|press) begin
          mask_nxt  = press;
          win_nxt   = WIN_LOAD;
          state_nxt = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Events in the final COLLECT cycle still make it into the vector,
        // because the emitted value is taken from mask_nxt below.
        mask_nxt = mask | press;
        if (win == 4'd0) begin
          state_nxt = S_EMIT;
        end else begin
          win_nxt = win - 4'd1;
        end
      end

      S_EMIT: begin
        mask_nxt  = 3'b000;
        state_nxt = S_HOLD;
      end

      S_HOLD: begin
        // Wait for every button to be released so one long press cannot
        // start a second round.
        if (db == 3'b000) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        mask_nxt  = 3'b000;
        win_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state decision so that A/B/C,
  // BUSY and ROUNDS change in the same cycle as the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      mask   <= 3'b000;
      win    <= 4'd0;
      abc_q  <= 3'b000;
      BUSY   <= 1'b0;
      ROUNDS <= 8'd0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      win   <= win_nxt;
      BUSY  <= (state_nxt != S_IDLE);
      if (state_nxt == S_EMIT) begin
        abc_q  <= mask_nxt;
        ROUNDS <= ROUNDS + 8'd1;
      end else begin
        abc_q  <= 3'b000;
      end
    end
  end

  assign A = abc_q[2];
  assign B = abc_q[1];
  assign C = abc_q[0];

endmodule

// File: tb/tb_hgame_btn_front.sv
// Purpose : directed self-checking bench for hgame_btn_front (DB_CYCLES=4, WIN_CYCLES=3).
// Latency : expectations follow the synchronizer setting (HGAME_BTN_SYNC_EN adds 2 cycles).
// Backpress: n/a; every round pulse is observed and counted by tick().
module tb_hgame_btn_front;

  localparam int DB  = 4;
  localparam int WIN = 3;
`ifdef HGAME_BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // A button raised in cycle 0 gives a press event in cycle PF and a round
  // vector in cycle PULSE.
  localparam int PF    = SYNC_LAT + DB;
  localparam int PULSE = PF + WIN + 1;

  logic       CLK;
  logic       RST;
  logic       BTN_A, BTN_B, BTN_C;
  logic       A, B, C;
  logic       BUSY;
  logic [7:0] ROUNDS;

  int checks   = 0;
  int failures = 0;

  // pulse observation, relative to the last start()
  int         cyc;
  int         pcnt;
  int         pfirst;
  int         plast;
  logic [2:0] pval;

  hgame_btn_front #(.DB_CYCLES(DB), .WIN_CYCLES(WIN)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN_A (BTN_A),
    .BTN_B (BTN_B),
    .BTN_C (BTN_C),
    .A     (A),
    .B     (B),
    .C     (C),
    .BUSY  (BUSY),
    .ROUNDS(ROUNDS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic start();
    cyc    = 0;
    pcnt   = 0;
    pfirst = -1;
    plast  = -1;
    pval   = 3'b000;
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if ({A, B, C} !== 3'b000) begin
      pcnt++;
      pval  = {A, B, C};
      plast = cyc;
      if (pfirst < 0) pfirst = cyc;
    end
  endtask

  task automatic reset_dut();
    RST   = 1'b0;
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    BTN_C = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    start();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {BTN_A, BTN_B, BTN_C} = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if ({A, B, C, BUSY, ROUNDS} !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold: outputs {A,B,C,BUSY,ROUNDS}=%h required 000", {A, B, C, BUSY, ROUNDS});
      end
    end
    {BTN_A, BTN_B, BTN_C} = 3'b000;
    RST = 1'b1;
    start();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({A, B, C, BUSY, ROUNDS} !== 12'h000) begin
        failures++;
        $display("FAIL reset_release cyc %0d: outputs=%h required 000", cyc, {A, B, C, BUSY, ROUNDS});
      end
    end
  endtask

  task automatic test_single_press();
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      BTN_A = (t < 20);
      tick();
      if (cyc == PF) begin
        checks++;
        if (BUSY !== 1'b0) begin
          failures++;
          $display("FAIL single_busy_idle: BUSY=%b required 0", BUSY);
        end
      end
      if (cyc == PF + 1) begin
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL single_busy_collect: BUSY=%b required 1", BUSY);
        end
      end
      if (cyc == 20 + SYNC_LAT + DB) begin
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL single_busy_hold: BUSY=%b required 1", BUSY);
        end
      end
      if (cyc == 20 + SYNC_LAT + DB + 1) begin
        checks++;
        if (BUSY !== 1'b0) begin
          failures++;
          $display("FAIL single_busy_release: BUSY=%b required 0", BUSY);
        end
      end
    end
    BTN_A = 1'b0;
    checks++;
    if (pcnt !== 1 || pfirst !== PULSE || pval !== 3'b100) begin
      failures++;
      $display("FAIL single_pulse: count=%0d cycle=%0d abc=%b required 1/%0d/100", pcnt, pfirst, pval, PULSE);
    end
    checks++;
    if (ROUNDS !== 8'd1) begin
      failures++;
      $display("FAIL single_rounds: ROUNDS=%0d required 1", ROUNDS);
    end
  endtask

  task automatic test_bounce();
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      BTN_B = (t < 2) || (t >= 3 && t < 18);
      tick();
    end
    BTN_B = 1'b0;
    checks++;
    if (pcnt !== 1 || pfirst !== 3 + PULSE || pval !== 3'b010) begin
      failures++;
      $display("FAIL bounce_pulse: count=%0d cycle=%0d abc=%b required 1/%0d/010", pcnt, pfirst, pval, 3 + PULSE);
    end
    checks++;
    if (ROUNDS !== 8'd1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL bounce_rounds: ROUNDS=%0d BUSY=%b required 1/0", ROUNDS, BUSY);
    end
  endtask

  task automatic test_collect_window();
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      BTN_A = (t < 20);
      BTN_C = (t >= 2 && t < 20);
      tick();
    end
    {BTN_A, BTN_C} = 2'b00;
    checks++;
    if (pcnt !== 1 || pfirst !== PULSE || pval !== 3'b101) begin
      failures++;
      $display("FAIL window_pulse: count=%0d cycle=%0d abc=%b required 1/%0d/101", pcnt, pfirst, pval, PULSE);
    end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      BTN_A = (t < 15);
      BTN_B = (t < 15);
      tick();
    end
    {BTN_A, BTN_B} = 2'b00;
    checks++;
    if (pcnt !== 1 || pfirst !== PULSE || pval !== 3'b110) begin
      failures++;
      $display("FAIL same_cycle_pulse: count=%0d cycle=%0d abc=%b required 1/%0d/110", pcnt, pfirst, pval, PULSE);
    end
  endtask

  task automatic test_hold_ignore();
    reset_dut();
    for (int t = 0; t < 80; t++) begin
      BTN_A = (t < 30);
      BTN_C = (t >= 6 && t < 30) || (t >= 50 && t < 62);
      tick();
      if (cyc == PULSE) begin
        checks++;
        if ({A, B, C} !== 3'b100) begin
          failures++;
          $display("FAIL hold_first_abc: abc=%b required 100", {A, B, C});
        end
      end
      if (cyc == 25) begin
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL hold_busy: BUSY=%b required 1", BUSY);
        end
      end
    end
    {BTN_A, BTN_C} = 2'b00;
    checks++;
    if (pcnt !== 2 || plast !== 50 + PULSE || pval !== 3'b001) begin
      failures++;
      $display("FAIL hold_second_pulse: count=%0d cycle=%0d abc=%b required 2/%0d/001", pcnt, plast, pval, 50 + PULSE);
    end
    checks++;
    if (ROUNDS !== 8'd2) begin
      failures++;
      $display("FAIL hold_rounds: ROUNDS=%0d required 2", ROUNDS);
    end
  endtask

  // Continues from ROUNDS=2 left by test_hold_ignore.
  task automatic test_rounds_wrap();
    int bad;
    bad = 0;
    for (int r = 1; r <= 254; r++) begin
      start();
      for (int t = 0; t < 28; t++) begin
        BTN_A = (t < 8);
        tick();
      end
      if (pcnt != 1 || pfirst != PULSE || pval != 3'b100) bad++;
      if (r == 253) begin
        checks++;
        if (ROUNDS !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255: ROUNDS=%0d required 255", ROUNDS);
        end
      end
    end
    BTN_A = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL wrap_pulses: bad rounds=%0d required 0", bad);
    end
    checks++;
    if (ROUNDS !== 8'd0) begin
      failures++;
      $display("FAIL wrap_zero: ROUNDS=%0d required 0", ROUNDS);
    end
  endtask

  task automatic test_reset_collect();
    reset_dut();
    for (int t = 0; t < 28; t++) begin
      BTN_A = (t < 8);
      tick();
    end
    start();
    BTN_A = 1'b1;
    for (int t = 0; t < PF + 2; t++) tick();
    RST = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || ROUNDS !== 8'd0 || {A, B, C} !== 3'b000) begin
      failures++;
      $display("FAIL abort_immediate: BUSY=%b ROUNDS=%0d abc=%b required 0/0/000", BUSY, ROUNDS, {A, B, C});
    end
    tick();
    tick();
    tick();
    checks++;
    if (pcnt !== 0) begin
      failures++;
      $display("FAIL abort_no_pulse: count=%0d required 0", pcnt);
    end
    // Button stays held through reset release and must count as a new press.
    RST = 1'b1;
    start();
    for (int t = 0; t < 30; t++) begin
      BTN_A = (t < 20);
      tick();
    end
    BTN_A = 1'b0;
    checks++;
    if (pcnt !== 1 || pfirst !== PULSE || pval !== 3'b100) begin
      failures++;
      $display("FAIL held_through_reset: count=%0d cycle=%0d abc=%b required 1/%0d/100", pcnt, pfirst, pval, PULSE);
    end
  endtask

  initial begin
    RST   = 1'b1;
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    BTN_C = 1'b0;
    start();
    #2;
    test_reset();
    test_single_press();
    test_bounce();
    test_collect_window();
    test_same_cycle();
    test_hold_ignore();
    test_rounds_wrap();
    test_reset_collect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
